// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR unit.
//   - CSR address constants
//   - csr_op_e: low two bits of the CSR funct3
//   - bit positions inside mstatus / mie / mip
//   - state_e: run / wait-for-interrupt states
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MSTATUS_MPP  = 11;  // two bits, hardwired to 2'b11
    localparam int unsigned IRQ_MTI      = 7;   // MTIE / MTIP
    localparam int unsigned IRQ_MEI      = 11;  // MEIE / MEIP

    // funct3[2] only selects the immediate source, which is muxed upstream
    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        S_RUN = 1'b0,
        S_WFI = 1'b1
    } state_e;

endpackage

// File: rtl/csr_unit_counter64.sv
// csr_counter64: 64-bit counter with independent 32-bit half writes.
//   clk, rst (async, active-low)
//   inc    : count up by one this cycle
//   wr_lo  : load wdata into bits [31:0] (overrides the increment of that half)
//   wr_hi  : load wdata into bits [63:32] (overrides the carry into that half)
//   wdata  : write data
//   value  : current 64-bit count
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [31:0] lo_q;
    logic [31:0] hi_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            if (wr_lo) begin
                lo_q <= wdata;
            end else if (inc) begin
                lo_q <= lo_q + 32'd1;
            end
            // carry comes from the pre-write low word, so a low-half write
            // leaves the high half's normal behaviour intact
            if (wr_hi) begin
                hi_q <= wdata;
            end else if (inc && (lo_q == '1)) begin
                hi_q <= hi_q + 32'd1;
            end
        end
    end

    assign value = {hi_q, lo_q};

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap controller for the RV32 pipeline.
// Optional feature macro: CSR_COUNTER_EN (mcycle/minstret counters).
// Ports:
//   clk, rst (async, active-low)
//   ex_valid_i, stall_i           : EX instruction qualifiers
//   csr_en_i, csr_op_i, csr_addr_i, csr_wsrc_i, csr_src_zero_i : CSR access
//   ex_pc_i, mret_i, wfi_i        : EX PC and special instructions
//   retire_i                      : instruction retired this cycle
//   ext_irq_i, timer_irq_i        : level interrupt inputs
//   csr_rdata_o                   : old CSR value (combinational)
//   redirect_o, redirect_pc_o     : front-end redirect (combinational)
//   wfi_stall_o                   : hold IF/ID/EX while sleeping
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0001_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        stall_i,
    input  logic        csr_en_i,
    input  logic [2:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wsrc_i,
    input  logic        csr_src_zero_i,
    input  logic [31:0] ex_pc_i,
    input  logic        mret_i,
    input  logic        wfi_i,
    input  logic        retire_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    output logic [31:0] csr_rdata_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        wfi_stall_o
);

    state_e      state_q, state_d;
    logic        mstatus_mie_q, mstatus_mpie_q, meie_q, mtie_q;
    logic [31:2] mtvec_q, mepc_q, shadow_q;
    logic [31:0] mstatus_v, mie_v, mip_v, wnew;
    logic        wake, irq, go, trap_wfi, trap, mret_take, wfi_enter, do_write;
    logic        unused_bits;
    csr_op_e     op;

`ifdef CSR_COUNTER_EN
    logic [63:0] mcycle_v, minstret_v;

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (do_write && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi (do_write && (csr_addr_i == CSR_MCYCLEH)),
        .wdata (wnew),
        .value (mcycle_v)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_i),
        .wr_lo (do_write && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi (do_write && (csr_addr_i == CSR_MINSTRETH)),
        .wdata (wnew),
        .value (minstret_v)
    );

    assign unused_bits = ^{ex_pc_i[1:0], csr_op_i[2], wnew[1:0]};
`else
    assign unused_bits = ^{ex_pc_i[1:0], csr_op_i[2], wnew[1:0], retire_i};
`endif

    // CSR views and read mux
    always_comb begin
        mstatus_v                    = '0;
        mstatus_v[MSTATUS_MIE]       = mstatus_mie_q;
        mstatus_v[MSTATUS_MPIE]      = mstatus_mpie_q;
        mstatus_v[MSTATUS_MPP +: 2]  = 2'b11;
        mie_v                        = '0;
        mie_v[IRQ_MEI]               = meie_q;
        mie_v[IRQ_MTI]               = mtie_q;
        mip_v                        = '0;
        mip_v[IRQ_MEI]               = ext_irq_i;
        mip_v[IRQ_MTI]               = timer_irq_i;

        case (csr_addr_i)
            CSR_MSTATUS:   csr_rdata_o = mstatus_v;
            CSR_MIE:       csr_rdata_o = mie_v;
            CSR_MTVEC:     csr_rdata_o = {mtvec_q, 2'b00};
            CSR_MEPC:      csr_rdata_o = {mepc_q, 2'b00};
            CSR_MIP:       csr_rdata_o = mip_v;
            CSR_MHARTID:   csr_rdata_o = HART_ID;
`ifdef CSR_COUNTER_EN
            CSR_MCYCLE:    csr_rdata_o = mcycle_v[31:0];
            CSR_MCYCLEH:   csr_rdata_o = mcycle_v[63:32];
            CSR_MINSTRET:  csr_rdata_o = minstret_v[31:0];
            CSR_MINSTRETH: csr_rdata_o = minstret_v[63:32];
`endif
            default:       csr_rdata_o = '0;
        endcase
    end

    // Trap / return / write arbitration
    always_comb begin
        op        = csr_op_e'(csr_op_i[1:0]);
        wake      = (meie_q & ext_irq_i) | (mtie_q & timer_irq_i);
        irq       = mstatus_mie_q & wake;
        go        = ex_valid_i & ~stall_i & (state_q == S_RUN);
        // wake-up from WFI with interrupts enabled is taken as a trap
        trap_wfi  = (state_q == S_WFI) & irq;
        trap      = (go & irq) | trap_wfi;
        mret_take = go & ~irq & mret_i;
        wfi_enter = go & ~irq & wfi_i;

        wnew     = csr_rdata_o;
        do_write = 1'b0;
        case (op)
            CSR_RW: begin
                wnew     = csr_wsrc_i;
                do_write = 1'b1;
            end
            CSR_RS: begin
                wnew     = csr_rdata_o | csr_wsrc_i;
                do_write = ~csr_src_zero_i;
            end
            CSR_RC: begin
                wnew     = csr_rdata_o & ~csr_wsrc_i;
                do_write = ~csr_src_zero_i;
            end
            default: ;
        endcase
        do_write = do_write & csr_en_i & go & ~irq;

        redirect_o    = trap | mret_take;
        redirect_pc_o = '0;
        if (trap) begin
            redirect_pc_o = {mtvec_q, 2'b00};
        end else if (mret_take) begin
            redirect_pc_o = {mepc_q, 2'b00};
        end
    end

    // FSM next state / outputs
    always_comb begin
        state_d     = state_q;
        wfi_stall_o = 1'b0;
        case (state_q)
            S_RUN: if (wfi_enter) state_d = S_WFI;
            S_WFI: begin
                wfi_stall_o = 1'b1;
                if (wake) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            meie_q         <= 1'b0;
            mtie_q         <= 1'b0;
            mtvec_q        <= MTVEC_RESET[31:2];
            mepc_q         <= '0;
            shadow_q       <= '0;
        end else begin
            if (trap) begin
                mepc_q         <= trap_wfi ? shadow_q : ex_pc_i[31:2];
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (mret_take) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (do_write) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= wnew[MSTATUS_MIE];
                        mstatus_mpie_q <= wnew[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        meie_q <= wnew[IRQ_MEI];
                        mtie_q <= wnew[IRQ_MTI];
                    end
                    CSR_MTVEC: mtvec_q <= wnew[31:2];
                    CSR_MEPC:  mepc_q  <= wnew[31:2];
                    default: ;
                endcase
            end
            if (wfi_enter) begin
                shadow_q <= ex_pc_i[31:2] + 30'd1;
            end
        end
    end

endmodule
